// File: rtl/layer_sched_if.sv
// rtl/layer_sched_if.sv - Layer command channel from the control/status block.
interface layer_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op_type;
  logic [3:0]  cmd_stride;
  logic [7:0]  cmd_kernel;
  logic [7:0]  cmd_i_side;
  logic [7:0]  cmd_o_side;
  logic [15:0] cmd_i_channel;
  logic [15:0] cmd_o_channel;

  modport master (
    output cmd_valid, cmd_op_type, cmd_stride, cmd_kernel, cmd_i_side, cmd_o_side,
           cmd_i_channel, cmd_o_channel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op_type, cmd_stride, cmd_kernel, cmd_i_side, cmd_o_side,
           cmd_i_channel, cmd_o_channel,
    output cmd_ready
  );
endinterface

// File: rtl/layer_sched.sv
// rtl/layer_sched.sv - Splits one layer command into engine passes (rows inner, channel groups outer).
module layer_sched #(
  parameter int          BURST_LEN      = 8,
  parameter int          ENG_RST_CYCLES = 2,
  parameter logic [31:0] TIMEOUT        = 32'd1048576
) (
  input  logic         clk,
  input  logic         rst,
  layer_sched_if.slave cmd,
  output logic         engine_valid_o,
  output logic         engine_rst_o,
  output logic [2:0]   op_type_o,
  output logic [3:0]   stride_o,
  output logic [7:0]   kernel_o,
  output logic [7:0]   i_side_o,
  output logic [7:0]   o_side_o,
  output logic [15:0]  i_channel_o,
  output logic [15:0]  o_channel_o,
  output logic [7:0]   kernel_size_o,
  output logic [15:0]  stride2_o,
  input  logic         gemm_finish_i,
  output logic         load_req_o,
  input  logic         load_done_i,
  output logic [7:0]   row_idx_o,
  output logic [15:0]  grp_idx_o,
  output logic         layer_done_o,
  output logic         err_o
);
  localparam int          GRP_SHIFT = $clog2(BURST_LEN);
  localparam logic [16:0] GRP_ROUND = 17'(BURST_LEN - 1);
  localparam logic [7:0]  RST_LAST  = 8'(ENG_RST_CYCLES - 1);
  localparam logic [31:0] RUN_LAST  = TIMEOUT - 32'd1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ENG_RST, S_NEXT, S_DONE} state_e;

  state_e      state_q;
  logic        cmd_ready_q, engine_valid_q, engine_rst_q, load_req_q, layer_done_q, err_q;
  logic [2:0]  op_type_q;
  logic [3:0]  stride_q;
  logic [7:0]  kernel_q, i_side_q, o_side_q, kernel_size_q, row_q, row_total_q;
  logic [15:0] i_channel_q, o_channel_q, stride2_q, grp_q, grp_total_q;
  logic [31:0] run_cnt_q;
  logic [7:0]  rst_cnt_q;
  logic        abort_q;

  logic        op_ok_d;
  logic [16:0] grp_ch_d;
  logic [15:0] grp_ceil_d, grp_total_d;
  logic [7:0]  row_total_d;
  logic        row_wrap_d, grp_last_d;

  // Pass totals are computed from the live command so they can be latched on accept.
  always_comb begin
    op_ok_d     = (cmd.cmd_op_type == 3'd1) || (cmd.cmd_op_type == 3'd2) || (cmd.cmd_op_type == 3'd3);
    grp_ch_d    = {1'b0, (cmd.cmd_op_type == 3'd1) ? cmd.cmd_o_channel : cmd.cmd_i_channel} + GRP_ROUND;
    grp_ceil_d  = 16'(grp_ch_d >> GRP_SHIFT);
    grp_total_d = (grp_ceil_d == 16'd0) ? 16'd1 : grp_ceil_d;
    row_total_d = cmd.cmd_o_side;
    if ((cmd.cmd_op_type == 3'd3) || (cmd.cmd_o_side == 8'd0)) row_total_d = 8'd1;
    row_wrap_d  = ({1'b0, row_q} + 9'd1) >= {1'b0, row_total_q};
    grp_last_d  = ({1'b0, grp_q} + 17'd1) >= {1'b0, grp_total_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cmd_ready_q    <= 1'b0;
      engine_valid_q <= 1'b0;
      engine_rst_q   <= 1'b1;
      load_req_q     <= 1'b0;
      layer_done_q   <= 1'b0;
      err_q          <= 1'b0;
      op_type_q      <= '0;
      stride_q       <= '0;
      kernel_q       <= '0;
      i_side_q       <= '0;
      o_side_q       <= '0;
      i_channel_q    <= '0;
      o_channel_q    <= '0;
      kernel_size_q  <= '0;
      stride2_q      <= '0;
      row_q          <= '0;
      grp_q          <= '0;
      row_total_q    <= 8'd1;
      grp_total_q    <= 16'd1;
      run_cnt_q      <= '0;
      rst_cnt_q      <= '0;
      abort_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          layer_done_q <= 1'b0;
          engine_rst_q <= 1'b0;
          if (cmd.cmd_valid && cmd_ready_q) begin
            cmd_ready_q   <= 1'b0;
            op_type_q     <= cmd.cmd_op_type;
            stride_q      <= cmd.cmd_stride;
            kernel_q      <= cmd.cmd_kernel;
            i_side_q      <= cmd.cmd_i_side;
            o_side_q      <= cmd.cmd_o_side;
            i_channel_q   <= cmd.cmd_i_channel;
            o_channel_q   <= cmd.cmd_o_channel;
            kernel_size_q <= cmd.cmd_kernel * cmd.cmd_kernel;
            stride2_q     <= {8'b0, cmd.cmd_kernel} * {12'b0, cmd.cmd_stride};
            row_total_q   <= row_total_d;
            grp_total_q   <= grp_total_d;
            row_q         <= '0;
            grp_q         <= '0;
            abort_q       <= 1'b0;
            err_q         <= !op_ok_d;
            load_req_q    <= op_ok_d;
            state_q       <= op_ok_d ? S_LOAD : S_DONE;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_done_i) begin
            load_req_q     <= 1'b0;
            engine_valid_q <= 1'b1;
            run_cnt_q      <= '0;
            state_q        <= S_RUN;
          end
        end
        S_RUN: begin
          run_cnt_q <= run_cnt_q + 32'd1;
          if (gemm_finish_i || (run_cnt_q == RUN_LAST)) begin
            if (!gemm_finish_i) begin
              err_q   <= 1'b1;
              abort_q <= 1'b1;
            end
            engine_valid_q <= 1'b0;
            engine_rst_q   <= 1'b1;
            rst_cnt_q      <= '0;
            state_q        <= S_ENG_RST;
          end
        end
        S_ENG_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            engine_rst_q <= 1'b0;
            state_q      <= abort_q ? S_DONE : S_NEXT;
          end else begin
            rst_cnt_q <= rst_cnt_q + 8'd1;
          end
        end
        S_NEXT: begin
          if (!row_wrap_d) begin
            row_q      <= row_q + 8'd1;
            load_req_q <= 1'b1;
            state_q    <= S_LOAD;
          end else if (grp_last_d) begin
            state_q <= S_DONE;
          end else begin
            row_q      <= '0;
            grp_q      <= grp_q + 16'd1;
            load_req_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_DONE: begin
          layer_done_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready     = cmd_ready_q;
  assign engine_valid_o    = engine_valid_q;
  assign engine_rst_o      = engine_rst_q;
  assign op_type_o         = op_type_q;
  assign stride_o          = stride_q;
  assign kernel_o          = kernel_q;
  assign i_side_o          = i_side_q;
  assign o_side_o          = o_side_q;
  assign i_channel_o       = i_channel_q;
  assign o_channel_o       = o_channel_q;
  assign kernel_size_o     = kernel_size_q;
  assign stride2_o         = stride2_q;
  assign load_req_o        = load_req_q;
  assign row_idx_o         = row_q;
  assign grp_idx_o         = grp_q;
  assign layer_done_o      = layer_done_q;
  assign err_o             = err_q;
endmodule

// File: tb/tb_layer_sched.sv
// tb/tb_layer_sched.sv - Scoreboard bench for layer_sched pass sequencing.
module tb_layer_sched;
  localparam int BL  = 8;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_sched_if cmd_if();

  logic        engine_valid, engine_rst, gemm_finish, load_req, load_done, layer_done, err;
  logic [2:0]  op_type;
  logic [3:0]  stride;
  logic [7:0]  kernel, i_side, o_side, kernel_size, row_idx;
  logic [15:0] i_channel, o_channel, stride2, grp_idx;

  layer_sched #(.BURST_LEN(BL), .ENG_RST_CYCLES(2), .TIMEOUT(32'd50)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if.slave),
    .engine_valid_o(engine_valid), .engine_rst_o(engine_rst),
    .op_type_o(op_type), .stride_o(stride), .kernel_o(kernel), .i_side_o(i_side),
    .o_side_o(o_side), .i_channel_o(i_channel), .o_channel_o(o_channel),
    .kernel_size_o(kernel_size), .stride2_o(stride2), .gemm_finish_i(gemm_finish),
    .load_req_o(load_req), .load_done_i(load_done), .row_idx_o(row_idx),
    .grp_idx_o(grp_idx), .layer_done_o(layer_done), .err_o(err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [23:0] exp_q[$];  // {row, grp} of each expected pass

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int op, input int k, input int s, input int isd, input int osd,
                          input int ich, input int och);
    int g, r;
    for (int i = 0; i < 20 && !cmd_if.cmd_ready; i++) step();
    if (!cmd_if.cmd_ready) check("cmd_ready_wait", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid     = 1'b1;
    cmd_if.cmd_op_type   = 3'(op);
    cmd_if.cmd_kernel    = 8'(k);
    cmd_if.cmd_stride    = 4'(s);
    cmd_if.cmd_i_side    = 8'(isd);
    cmd_if.cmd_o_side    = 8'(osd);
    cmd_if.cmd_i_channel = 16'(ich);
    cmd_if.cmd_o_channel = 16'(och);
    if (op >= 1 && op <= 3) begin
      g = ((op == 1 ? och : ich) + BL - 1) / BL;
      if (g == 0) g = 1;
      r = (op == 3 || osd == 0) ? 1 : osd;
      for (int gi = 0; gi < g; gi++)
        for (int ri = 0; ri < r; ri++)
          exp_q.push_back({8'(ri), 16'(gi)});
    end
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Acts as DMA and engine; optionally pulses rst 3 cycles into RUN of pass rst_pass.
  task automatic serve(input int gdelay, input bit early, input int rst_pass, input int budget,
                       output int npass, output int ndone, output logic err_done, output bit was_reset);
    int ld_due, gf_due, ef_due, rst_due, ev_run, er_run, exp_ev;
    logic p_lr, p_ev, p_er;
    logic [23:0] e;
    npass = 0; ndone = 0; err_done = 1'b0; was_reset = 1'b0;
    ld_due = -10; gf_due = -10; ef_due = -10; rst_due = -10; ev_run = 0; er_run = 0;
    p_lr = 1'b0; p_ev = 1'b0; p_er = 1'b0;
    exp_ev = (gdelay < 0) ? TMO : gdelay + 1;
    for (int c = 0; c < budget && ndone == 0 && !was_reset; c++) begin
      if (c == rst_due + 1) begin
        was_reset = 1'b1;
        check("rst_engine_rst", engine_rst, 1);
        check("rst_engine_valid", engine_valid, 0);
        check("rst_load_req", load_req, 0);
        check("rst_cmd_ready", cmd_if.cmd_ready, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_row_grp", {row_idx, grp_idx}, 0);
      end else begin
        if (load_req && !p_lr) begin
          npass++;
          if (exp_q.size() == 0) check("extra_pass", npass, 0);
          else begin
            e = exp_q.pop_front();
            check("row_idx", row_idx, e[23:16]);
            check("grp_idx", grp_idx, e[15:0]);
          end
          ld_due = c + 1;
          if (early) ef_due = c;
        end
        if (engine_valid) begin
          if (!p_ev) begin
            gf_due = (gdelay < 0) ? -10 : c + gdelay;
            if (npass == rst_pass) rst_due = c + 3;
          end
          ev_run++;
        end else if (p_ev) begin
          check("ev_len", ev_run, exp_ev);
          ev_run = 0;
        end
        if (engine_rst) er_run++;
        else if (p_er) begin
          check("er_len", er_run, 2);
          er_run = 0;
        end
        if (layer_done) begin
          ndone++;
          err_done = err;
        end
        p_lr = load_req; p_ev = engine_valid; p_er = engine_rst;
      end
      load_done   = (c == ld_due);
      gemm_finish = (c == gf_due) || (c == ef_due);
      rst         = (c == rst_due);
      step();
    end
    load_done = 1'b0; gemm_finish = 1'b0; rst = 1'b0;
    if (ndone == 0 && !was_reset) check("serve_budget", ndone, 1);
  endtask

  initial begin
    int np, nd, cnt;
    logic ed;
    bit wr;
    rst = 1'b1; load_done = 1'b0; gemm_finish = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op_type = '0; cmd_if.cmd_stride = '0;
    cmd_if.cmd_kernel = '0; cmd_if.cmd_i_side = '0; cmd_if.cmd_o_side = '0;
    cmd_if.cmd_i_channel = '0; cmd_if.cmd_o_channel = '0;
    repeat (3) step();
    check("reset_cmd_ready", cmd_if.cmd_ready, 0);
    check("reset_engine_rst", engine_rst, 1);
    check("reset_outputs", {load_req, engine_valid, layer_done, err}, 0);
    rst = 1'b0;
    step();
    check("post_reset_cmd_ready", cmd_if.cmd_ready, 1);
    check("post_reset_engine_rst", engine_rst, 0);

    // CONV, 4 rows x 2 groups
    send_cmd(1, 3, 2, 9, 4, 5, 16);
    check("conv_kernel_size", kernel_size, 9);
    check("conv_stride2", stride2, 6);
    check("conv_fields", {op_type, o_side, o_channel}, {3'd1, 8'd4, 16'd16});
    check("conv_load_req_t1", load_req, 1);
    check("conv_cmd_ready_busy", cmd_if.cmd_ready, 0);
    serve(10, 1'b0, -1, 600, np, nd, ed, wr);
    check("conv_passes", np, 8);
    check("conv_done", nd, 1);
    check("conv_err", ed, 0);
    check("conv_sb_empty", exp_q.size(), 0);
    check("layer_done_pulse", layer_done, 0);

    // APOOL, 3 groups of one row, kernel 20 truncates kernel_size
    send_cmd(3, 20, 1, 8, 7, 24, 0);
    check("apool_kernel_size", kernel_size, 144);
    check("apool_stride2", stride2, 20);
    serve(4, 1'b0, -1, 300, np, nd, ed, wr);
    check("apool_passes", np, 3);
    check("apool_sb_empty", exp_q.size(), 0);

    // Illegal op: err, no passes, layer_done two cycles after accept
    send_cmd(5, 3, 1, 4, 4, 8, 8);
    check("badop_err", err, 1);
    check("badop_done_t1", layer_done, 0);
    cnt = engine_valid ? 1 : 0;
    step();
    check("badop_done_t2", layer_done, 1);
    cnt += engine_valid ? 1 : 0;
    step();
    cnt += engine_valid ? 1 : 0;
    check("badop_done_t3", layer_done, 0);
    check("badop_no_engine_valid", cnt, 0);

    // Timeout abort on a single-pass layer
    send_cmd(1, 3, 1, 4, 1, 8, 8);
    check("err_cleared_on_accept", err, 0);
    serve(-1, 1'b0, -1, 300, np, nd, ed, wr);
    check("tmo_passes", np, 1);
    check("tmo_done", nd, 1);
    check("tmo_err", ed, 1);

    // gemm_finish during LOAD is ignored
    send_cmd(1, 3, 1, 4, 2, 8, 8);
    serve(5, 1'b1, -1, 300, np, nd, ed, wr);
    check("early_passes", np, 2);
    check("early_err", ed, 0);

    // Reset in RUN of pass 3
    send_cmd(1, 3, 2, 9, 4, 5, 16);
    serve(10, 1'b0, 3, 600, np, nd, ed, wr);
    check("midrst_seen", wr, 1);
    check("midrst_passes", np, 3);
    check("midrst_no_done", nd, 0);
    exp_q.delete();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += layer_done ? 1 : 0;
      step();
    end
    check("midrst_quiet", cnt, 0);
    send_cmd(1, 4, 3, 9, 2, 8, 8);
    check("restart_kernel_size", kernel_size, 16);
    check("restart_stride2", stride2, 12);
    serve(3, 1'b0, -1, 300, np, nd, ed, wr);
    check("restart_passes", np, 2);
    check("restart_done", nd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/layer_sched.md
# layer_sched

Layer sequencer for the convolution/pooling engine. It accepts one layer command from the control/status block and breaks the layer into engine passes. A pass is one output row for one `BURST_LEN`-wide channel group. For each pass it handshakes RAM preload with the DMA, drives `engine_valid` and the static engine configuration, and waits for `gemm_finish`. Because the engine parks in its wait state after a pass, the sequencer then pulses the engine reset. It sits between the CSB/host command path and the engine/DMA pair.

## Interface
Parameters:
- `BURST_LEN`, 8: channels per engine pass.
- `ENG_RST_CYCLES`, 2: width of the engine reset pulse between passes, in cycles.
- `TIMEOUT`, 32'd1048576: maximum cycles allowed in RUN before the pass is aborted.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a layer command is present on the `cmd_*` inputs.
- `cmd_ready` out 1: command accepted this cycle when `cmd_valid & cmd_ready`.
- `cmd_op_type` in 3: operation code; 1 = CONV, 2 = MPOOL, 3 = APOOL.
- `cmd_stride` in 4, `cmd_kernel` in 8, `cmd_i_side` in 8, `cmd_o_side` in 8: layer geometry.
- `cmd_i_channel` in 16, `cmd_o_channel` in 16: layer channel counts.
- `engine_valid` out 1: pass-active strobe to the engine.
- `engine_rst` out 1: reset to the engine.
- `op_type` out 3, `stride` out 4, `kernel` out 8, `i_side` out 8, `o_side` out 8, `i_channel` out 16, `o_channel` out 16: registered copies of the captured command.
- `kernel_size` out 8: kernel × kernel.
- `stride2` out 16: kernel × stride.
- `gemm_finish` in 1: engine reports the pass complete.
- `load_req` out 1: asks the DMA to preload data/weight/bias RAMs for the current pass.
- `load_done` in 1: DMA reports the preload complete.
- `row_idx` out 8, `grp_idx` out 16: current pass coordinates, for DMA addressing.
- `layer_done` out 1: one-cycle pulse at the end of the layer.
- `err` out 1: sticky error flag; cleared on the next command accept.

## Operation
- States: IDLE, LOAD, RUN, ENG_RST, NEXT, DONE.
- IDLE:
  - `cmd_ready` = 1.
  - On accept: capture all `cmd_*` fields, compute `kernel_size` and `stride2`, clear `row_idx`/`grp_idx`/`err`, go to LOAD.
  - If `cmd_op_type` ∉ {1,2,3}: set `err` and go to DONE (no passes run).
- LOAD: `load_req` = 1. When `load_done` = 1, go to RUN. `gemm_finish` is ignored in this state.
- RUN:
  - `engine_valid` = 1; the cycle counter increments each cycle.
  - When `gemm_finish` = 1, go to ENG_RST.
  - If the counter reaches `TIMEOUT`, set `err` and go to ENG_RST with an abort flag set.
- ENG_RST: `engine_rst` = 1 for exactly `ENG_RST_CYCLES` cycles, then go to NEXT (or to DONE if the abort flag is set).
- NEXT: advance the pass counters, then go to LOAD, or to DONE after the last pass.
- DONE: `layer_done` = 1 for one cycle, then go to IDLE.

Pass counting:
- Number of groups G:
  - CONV: ceil(`o_channel` / `BURST_LEN`).
  - MPOOL/APOOL: ceil(`i_channel` / `BURST_LEN`).
  - If G = 0, force G = 1.
- Number of rows R:
  - CONV/MPOOL: `o_side`; if `o_side` = 0, force R = 1.
  - APOOL: R = 1 (global average).
- Order: rows inner, groups outer. In NEXT:
  - If `row_idx` + 1 < R: increment `row_idx`.
  - Else: clear `row_idx` and increment `grp_idx`.
  - If `grp_idx` + 1 = G on the row wrap: go to DONE instead.

Arithmetic:
- `kernel_size` = low 8 bits of the 16-bit product (truncates for kernel > 15).
- `stride2` = {8'b0, kernel} × {12'b0, stride}, 16-bit.
- The ceil divide uses the add-(`BURST_LEN`−1)-then-shift form; `BURST_LEN` must be a power of two.

## Timing
- Reset values:
  - State IDLE; `cmd_ready` 0 during reset, 1 on the first cycle after.
  - `engine_rst` 1 (held through reset, deasserted the cycle after `rst` falls).
  - All other outputs 0.
- All outputs are registered, i.e. they change the cycle after the triggering input is sampled.
- Pass timing:
  - Accept at cycle T: `load_req` = 1 from T+1.
  - `load_done` sampled at cycle L: `engine_valid` = 1 from L+1.
  - `gemm_finish` sampled at cycle F: `engine_valid` = 0 and `engine_rst` = 1 from F+1 through F+`ENG_RST_CYCLES`.
  - NEXT occurs at F+`ENG_RST_CYCLES`+1; `load_req` or `layer_done` follows one cycle later.
- `row_idx`/`grp_idx` are stable from LOAD entry through the end of ENG_RST.
- `cmd_valid` in any state other than IDLE is ignored; `cmd_ready` is 0 there.
- Reset mid-layer: state returns to IDLE immediately, `engine_rst` = 1, and no `layer_done` is issued.

## Test plan
- CONV, `o_side`=4, `o_channel`=16:
  - Each pass is acked by `load_done` one cycle after `load_req`, and by `gemm_finish` 10 cycles after `engine_valid` rises.
  - Required: 8 passes in order (row 0..3, grp 0), then (row 0..3, grp 1); one `layer_done`; `kernel_size`/`stride2` match the command (kernel 3, stride 2 → 9 and 6).
- APOOL, `i_channel`=24:
  - Required: 3 passes, all with `row_idx`=0; `grp_idx` 0,1,2.
- `cmd_op_type`=5:
  - Required: `err`=1, `layer_done` on the 2nd cycle after accept, `engine_valid` never asserted.
- TIMEOUT=50, `gemm_finish` never sent:
  - Required: `engine_valid` is high for exactly 50 cycles, then a 2-cycle `engine_rst`, then `layer_done` with `err`=1.
- `rst` pulsed during RUN of pass 3:
  - Required: outputs go to their reset values, `engine_rst` is held, no `layer_done`; a new command afterwards starts at row 0, grp 0.
- `gemm_finish` asserted during LOAD:
  - Required: ignored; the pass still enters RUN and completes only on a later `gemm_finish`.
